softplus_vec_ctrl: RTL and testbench
====================================

Name: softplus_vec_ctrl

Overview:
- Sequencer that runs the piecewise softplus approximation over a vector of Q8.8 samples held in the VAE's shared activation SRAM.
- Reads each element, computes softplus and writes the result to a destination region.
- Sits between the layer controller (start/done) and the single-port SRAM read/write interfaces.
- Unpipelined, one element in flight, with write-side backpressure.

Parameters:
- ADDR_W, 8, width of SRAM addresses and of the element count.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- src_base  in  ADDR_W  first source address; latched on accepted start
- dst_base  in  ADDR_W  first destination address; latched on accepted start
- len  in  ADDR_W  element count; latched on accepted start; 0 is legal
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of job
- rd_en  out  1  SRAM read strobe
- rd_addr  out  ADDR_W  SRAM read address
- rd_data  in  16  SRAM read data, valid exactly 1 cycle after rd_en
- wr_en  out  1  write request, held until accepted
- wr_addr  out  ADDR_W  write address, stable while wr_en high
- wr_data  out  16  result, stable while wr_en high
- wr_ready  in  1  write accepted on a cycle where wr_en && wr_ready

Behaviour:
- Reset (async assert, sync deassert):
  - FSM goes to IDLE and index counter goes to 0.
  - busy, done, rd_en and wr_en go low.
  - rd_addr, wr_addr and wr_data go to 0.
  - Reset mid-job abandons the job with no done pulse.
- FSM states: IDLE, RD, CALC, WR, FIN.
- IDLE:
  - On start, latch src_base, dst_base and len, and clear idx.
  - Go to FIN if len==0, else go to RD.
  - start is ignored while busy.
- RD: rd_en=1 for one cycle, rd_addr=src_base+idx (modulo 2^ADDR_W). Go to CALC.
- CALC: capture rd_data, compute y, register it into wr_data. Go to WR.
- WR:
  - wr_en=1 with wr_addr=dst_base+idx (wraps). Stay while wr_ready=0.
  - On accept: if idx==len-1 go to FIN, else idx+=1 and go to RD.
- FIN: done=1 for exactly one cycle, busy still 1. Go to IDLE.
- Latency with wr_ready tied high:
  - start sampled at edge 0; done high during cycle 3*len+1.
  - len=0 gives done during cycle 1.
- Arithmetic (x = rd_data, signed Q8.8; k = x[15:8]):
  - Non-negative x (x[15]=0) offset: k=00 → 004D, 01 → 0037, 02 → 001F, 03 → 000F, 04 → 0007, any other k → 004D.
  - Negative x (x[15]=1) offset: k=FF → 004D, FE → 0037, FD → 001F, FC → 000F, FB → 0007, any other k → 0002.
  - y = (x[15] ? 0 : x) + offset, computed 17-bit unsigned.
  - If the sum exceeds 0x7FFF, y = 0x7FFF (saturate).
  - y is never negative.
- Address wrap: src and dst regions may wrap past 2^ADDR_W-1 to 0; no error.
- Overlap: src==dst is legal (in place), because each element is read before it is written.

Optional Feature:
- Macro SOFTPLUS_SAT_CNT_EN.
- Defined:
  - Adds output port sat_cnt, width ADDR_W.
  - Cleared on accepted start and on reset.
  - Increments in CALC whenever saturation fires; saturates at all-ones.
  - Holds its value after done until the next start.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-job (rst_n low during WR of element 2 of 4): busy, wr_en and done go low immediately; no done pulse; a new start with len=1 then completes normally.
- len=3, src_base=0x10, dst_base=0x20, mem[0x10..0x12]=0080, FF00, 0300, wr_ready=1: writes 00CD@0x20, 004D@0x21, 030F@0x22; done in cycle 10; busy high in cycles 1..10.
- Negative tail and wrap, len=2, src_base=0xFF, dst_base=0xFF, mem[0xFF]=F000, mem[0x00]=FB80: reads 0xFF then 0x00; writes 0002@0xFF and 0007@0x00.
- Saturation, len=1, x=7FF0: wr_data=7FFF; with SOFTPLUS_SAT_CNT_EN defined, sat_cnt=1 after done.
- Backpressure, len=2, wr_ready low for 5 cycles on the first write: wr_en, wr_addr and wr_data held stable; no second rd_en until the first write is accepted; done 5 cycles later than nominal.
- len=0 start: no rd_en and no wr_en; done in cycle 1; start pulsed while busy during another job is ignored (no extra done, latched len unchanged).

Source files
------------

// File: rtl/softplus_vec_ctrl.sv
// Softplus sequencer: reads Q8.8 samples from SRAM, writes piecewise softplus results.
// Optional saturation counter port enabled by SOFTPLUS_SAT_CNT_EN.
module softplus_vec_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    input  logic              wr_ready
`ifdef SOFTPLUS_SAT_CNT_EN
    ,
    output logic [ADDR_W-1:0] sat_cnt
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_len;
    logic [15:0]       r_wr_data;

    logic [7:0]  w_k;
    logic [15:0] w_off;
    logic [16:0] w_sum;
    logic        w_sat;
    logic [15:0] w_y;
    logic        w_last;

    assign w_k = rd_data[15:8];

    // Offset table indexed by the integer part of x
    always_comb begin
        w_off = 16'h004D;
        if (!rd_data[15]) begin
            case (w_k)
                8'h00:   w_off = 16'h004D;
                8'h01:   w_off = 16'h0037;
                8'h02:   w_off = 16'h001F;
                8'h03:   w_off = 16'h000F;
                8'h04:   w_off = 16'h0007;
                default: w_off = 16'h004D;
            endcase
        end else begin
            case (w_k)
                8'hFF:   w_off = 16'h004D;
                8'hFE:   w_off = 16'h0037;
                8'hFD:   w_off = 16'h001F;
                8'hFC:   w_off = 16'h000F;
                8'hFB:   w_off = 16'h0007;
                default: w_off = 16'h0002;
            endcase
        end
    end

    assign w_sum  = {1'b0, (rd_data[15] ? 16'h0000 : rd_data)} + {1'b0, w_off};
    assign w_sat  = w_sum > 17'h07FFF;
    assign w_y    = w_sat ? 16'h7FFF : w_sum[15:0];
    assign w_last = (r_idx + ONE) == r_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_src     <= '0;
            r_dst     <= '0;
            r_len     <= '0;
            r_wr_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src   <= src_base;
                        r_dst   <= dst_base;
                        r_len   <= len;
                        r_idx   <= '0;
                        r_state <= (len == '0) ? S_FIN : S_RD;
                    end
                end
                S_RD: r_state <= S_CALC;
                S_CALC: begin
                    r_wr_data <= w_y;
                    r_state   <= S_WR;
                end
                S_WR: begin
                    if (wr_ready) begin
                        if (w_last) begin
                            r_state <= S_FIN;
                        end else begin
                            r_idx   <= r_idx + ONE;
                            r_state <= S_RD;
                        end
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SOFTPLUS_SAT_CNT_EN
    logic [ADDR_W-1:0] r_sat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_sat_cnt <= '0;
        end else if (r_state == S_CALC && w_sat && r_sat_cnt != '1) begin
            r_sat_cnt <= r_sat_cnt + ONE;
        end
    end

    assign sat_cnt = r_sat_cnt;
`endif

    assign busy    = r_state != S_IDLE;
    assign done    = r_state == S_FIN;
    assign rd_en   = r_state == S_RD;
    assign wr_en   = r_state == S_WR;
    assign rd_addr = rd_en ? (r_src + r_idx) : '0;
    assign wr_addr = wr_en ? (r_dst + r_idx) : '0;
    assign wr_data = r_wr_data;

endmodule

// File: tb/tb_softplus_vec_ctrl.sv
// Randomized self-checking bench for softplus_vec_ctrl with a behavioural SRAM and reference model.
module tb_softplus_vec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  src_base;
    logic [7:0]  dst_base;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
`ifdef SOFTPLUS_SAT_CNT_EN
    logic [7:0]  sat_cnt;
`endif

    softplus_vec_ctrl #(.ADDR_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_base (src_base),
        .dst_base (dst_base),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready)
`ifdef SOFTPLUS_SAT_CNT_EN
        ,
        .sat_cnt  (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [256];
    logic [7:0]  rq[$];
    logic [7:0]  wq_a[$];
    logic [15:0] wq_d[$];
    logic [7:0]  er[$];
    logic [7:0]  ea[$];
    logic [15:0] ed[$];
    int          es;
    int g_edge = 0;
    int start_edge = 0;
    int done_edge = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int hold_err = 0;
    bit          w_pend = 1'b0;
    logic [7:0]  p_a;
    logic [15:0] p_d;

    // Bus monitor and SRAM model; sampled before the DUT's registers update
    always @(posedge clk) begin
        if (rst_n) begin
            if (start && !busy) start_edge = g_edge;
            if (busy) busy_cnt++;
            if (w_pend && (!wr_en || wr_addr != p_a || wr_data != p_d || rd_en))
                hold_err++;
            w_pend = wr_en && !wr_ready;
            p_a = wr_addr;
            p_d = wr_data;
            if (rd_en) begin
                rq.push_back(rd_addr);
                rd_data <= mem[rd_addr];
            end
            if (wr_en && wr_ready) begin
                wq_a.push_back(wr_addr);
                wq_d.push_back(wr_data);
                mem[wr_addr] = wr_data;
            end
            if (done) begin
                done_cnt++;
                done_edge = g_edge;
            end
        end else begin
            w_pend = 1'b0;
        end
        g_edge++;
    end

    // Unclamped softplus approximation from the signed value of x
    function automatic int sp_raw(input logic [15:0] x);
        int xv, k, off;
        xv = int'($signed(x));
        k = xv >>> 8;
        case (k)
            0, -1:   off = 77;
            1, -2:   off = 55;
            2, -3:   off = 31;
            3, -4:   off = 15;
            4, -5:   off = 7;
            default: off = (xv < 0) ? 2 : 77;
        endcase
        return ((xv < 0) ? 0 : xv) + off;
    endfunction

    function automatic void model_job(input logic [7:0] s, input logic [7:0] d,
                                      input logic [7:0] l);
        logic [15:0] m [256];
        logic [7:0] ra, wa;
        int y;
        m = mem;
        er.delete(); ea.delete(); ed.delete();
        es = 0;
        for (int i = 0; i < int'(l); i++) begin
            ra = 8'(int'(s) + i);
            wa = 8'(int'(d) + i);
            y = sp_raw(m[ra]);
            if (y > 32767) begin
                y = 32767;
                if (es < 255) es++;
            end
            er.push_back(ra);
            ea.push_back(wa);
            ed.push_back(16'(y));
            m[wa] = 16'(y);
        end
    endfunction

    task automatic start_job(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
        model_job(s, d, l);
        @(negedge clk);
        rq.delete(); wq_a.delete(); wq_d.delete();
        busy_cnt = 0;
        hold_err = 0;
        src_base = s;
        dst_base = d;
        len = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input bit rnd);
        int n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(negedge clk);
            if (rnd) wr_ready = 1'($urandom_range(0, 1));
            n++;
        end
        wr_ready = 1'b1;
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles", n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        src_base = '0; dst_base = '0; len = '0;
        wr_ready = 1'b1;
        rd_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, rd_en, wr_en} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000", {busy, done, rd_en, wr_en});
        end
        checks++;
        if ({rd_addr, wr_addr, wr_data} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {rd_addr, wr_addr, wr_data});
        end
`ifdef SOFTPLUS_SAT_CNT_EN
        checks++;
        if (sat_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_sat_cnt: got %h want 00", sat_cnt);
        end
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int d0 = done_cnt;
        mem[8'h10] = 16'h0080;
        mem[8'h11] = 16'hFF00;
        mem[8'h12] = 16'h0300;
        start_job(8'h10, 8'h20, 8'd3);
        wait_done(d0, 1'b0);
        checks++;
        if (wq_a.size() != 3 || wq_d[0] !== 16'h00CD || wq_d[1] !== 16'h004D ||
            wq_d[2] !== 16'h030F || wq_a[0] !== 8'h20 || wq_a[2] !== 8'h22) begin
            errors++;
            $display("FAIL basic_vectors: got %0d writes, first %h want 00CD@20 004D@21 030F@22",
                     wq_a.size(), (wq_d.size() > 0) ? wq_d[0] : 16'hxxxx);
        end
        for (int i = 0; i < ea.size() && i < wq_a.size(); i++) begin
            checks++;
            if (wq_a[i] !== ea[i] || wq_d[i] !== ed[i]) begin
                errors++;
                $display("FAIL basic_wr%0d: got %h@%h want %h@%h", i, wq_d[i], wq_a[i], ed[i], ea[i]);
            end
        end
        checks++;
        if (done_edge - start_edge != 10) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 10", done_edge - start_edge);
        end
        checks++;
        if (busy_cnt != 10) begin
            errors++;
            $display("FAIL basic_busy: got %0d cycles want 10", busy_cnt);
        end
    endtask

    task automatic test_wrap;
        int d0 = done_cnt;
        mem[8'hFF] = 16'hF000;
        mem[8'h00] = 16'hFB80;
        start_job(8'hFF, 8'hFF, 8'd2);
        wait_done(d0, 1'b0);
        checks++;
        if (rq.size() != 2 || rq[0] !== 8'hFF || rq[1] !== 8'h00) begin
            errors++;
            $display("FAIL wrap_reads: got %0d reads want FF,00", rq.size());
        end
        checks++;
        if (wq_a.size() != 2 || wq_a[0] !== 8'hFF || wq_d[0] !== 16'h0002 ||
            wq_a[1] !== 8'h00 || wq_d[1] !== 16'h0007) begin
            errors++;
            $display("FAIL wrap_writes: got %0d writes want 0002@FF 0007@00", wq_a.size());
        end
    endtask

    task automatic test_saturation;
        int d0 = done_cnt;
        mem[8'h80] = 16'h7FF0;
        start_job(8'h80, 8'h90, 8'd1);
        wait_done(d0, 1'b0);
        checks++;
        if (wq_d.size() != 1 || wq_d[0] !== 16'h7FFF) begin
            errors++;
            $display("FAIL sat_value: got %0d writes first %h want 7FFF",
                     wq_d.size(), (wq_d.size() > 0) ? wq_d[0] : 16'hxxxx);
        end
`ifdef SOFTPLUS_SAT_CNT_EN
        checks++;
        if (sat_cnt !== 8'd1) begin
            errors++;
            $display("FAIL sat_cnt: got %0d want 1", sat_cnt);
        end
`endif
    endtask

    task automatic test_backpressure;
        int d0 = done_cnt;
        int n = 0;
        mem[8'h60] = 16'h0123;
        mem[8'h61] = 16'hFD10;
        wr_ready = 1'b0;
        start_job(8'h60, 8'h70, 8'd2);
        while (!wr_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        wr_ready = 1'b1;
        wait_done(d0, 1'b0);
        checks++;
        if (hold_err != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d violations want 0", hold_err);
        end
        checks++;
        if (done_edge - start_edge != 12) begin
            errors++;
            $display("FAIL bp_latency: got %0d want 12", done_edge - start_edge);
        end
        checks++;
        if (wq_d.size() != 2 || wq_d[0] !== ed[0] || wq_d[1] !== ed[1]) begin
            errors++;
            $display("FAIL bp_data: got %0d writes want %h %h", wq_d.size(), ed[0], ed[1]);
        end
    endtask

    task automatic test_len0_and_ignore;
        int d0 = done_cnt;
        start_job(8'h30, 8'h31, 8'd0);
        wait_done(d0, 1'b0);
        checks++;
        if (rq.size() != 0 || wq_a.size() != 0 || done_edge - start_edge != 1) begin
            errors++;
            $display("FAIL len0: got reads %0d writes %0d latency %0d want 0 0 1",
                     rq.size(), wq_a.size(), done_edge - start_edge);
        end
        mem[8'h10] = 16'h0080;
        mem[8'h11] = 16'hFF00;
        mem[8'h12] = 16'h0300;
        d0 = done_cnt;
        start_job(8'h10, 8'h20, 8'd3);
        @(negedge clk);
        src_base = 8'hA0;
        len = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt != d0 + 1 || wq_a.size() != 3 || done_edge - start_edge != 10) begin
            errors++;
            $display("FAIL ignore_start: got dones %0d writes %0d latency %0d want 1 3 10",
                     done_cnt - d0, wq_a.size(), done_edge - start_edge);
        end
    endtask

    task automatic test_reset_midjob;
        int d0;
        int n = 0;
        for (int i = 0; i < 4; i++) mem[8'h40 + i] = 16'h0100 * 16'(i);
        start_job(8'h40, 8'h50, 8'd4);
        while (!(wq_a.size() == 1 && wr_en) && n < 50) begin
            @(negedge clk);
            n++;
        end
        d0 = done_cnt;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, wr_en, done, rd_en} !== 4'b0000 || wr_addr !== 8'h00 || wr_data !== 16'h0000) begin
            errors++;
            $display("FAIL midjob_reset: got ctrl %b addr %h data %h want 0",
                     {busy, wr_en, done, rd_en}, wr_addr, wr_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL midjob_no_done: got %0d dones want 0", done_cnt - d0);
        end
        d0 = done_cnt;
        start_job(8'h41, 8'h51, 8'd1);
        wait_done(d0, 1'b0);
        checks++;
        if (wq_a.size() != 1 || wq_a[0] !== 8'h51 || wq_d[0] !== ed[0] ||
            done_edge - start_edge != 4) begin
            errors++;
            $display("FAIL midjob_restart: got %0d writes latency %0d want 1 write %h@51 latency 4",
                     wq_a.size(), done_edge - start_edge, ed[0]);
        end
    endtask

    task automatic test_random;
        logic [7:0] s, d, l;
        int d0;
        for (int j = 0; j < 10; j++) begin
            for (int a = 0; a < 256; a++) begin
                case ($urandom_range(0, 2))
                    0: mem[a] = 16'($urandom);
                    1: mem[a] = {8'($urandom_range(0, 10) - 5), 8'($urandom)};
                    default: mem[a] = {8'h7F, 8'($urandom)};
                endcase
            end
            s = 8'($urandom);
            d = (j % 3 == 0) ? s : 8'($urandom);
            l = 8'($urandom_range(1, 8));
            d0 = done_cnt;
            start_job(s, d, l);
            wait_done(d0, 1'b1);
            checks++;
            if (wq_a.size() != ea.size() || rq.size() != er.size() || hold_err != 0) begin
                errors++;
                $display("FAIL rand%0d_counts: got wr %0d rd %0d hold %0d want %0d %0d 0",
                         j, wq_a.size(), rq.size(), hold_err, ea.size(), er.size());
            end
            for (int i = 0; i < ea.size() && i < wq_a.size() && i < rq.size(); i++) begin
                checks++;
                if (wq_a[i] !== ea[i] || wq_d[i] !== ed[i] || rq[i] !== er[i]) begin
                    errors++;
                    $display("FAIL rand%0d_el%0d: got rd %h wr %h@%h want rd %h wr %h@%h",
                             j, i, rq[i], wq_d[i], wq_a[i], er[i], ed[i], ea[i]);
                end
            end
`ifdef SOFTPLUS_SAT_CNT_EN
            checks++;
            if (int'(sat_cnt) != es) begin
                errors++;
                $display("FAIL rand%0d_sat_cnt: got %0d want %0d", j, sat_cnt, es);
            end
`endif
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_saturation();
        test_backpressure();
        test_len0_and_ignore();
        test_reset_midjob();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
